// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl -- registered sequencer for the LED / 7-segment output path.
//
// A start request runs a pattern sequence through four phases:
//   IDLE  -> RUN   : steps 0..lim-1, one step per prescaled tick
//   RUN   -> DWELL : waits dwl ticks (immediately on if dwl==0)
//   DWELL -> DONE  : holds until ack
//   DONE  -> IDLE
// stop aborts to IDLE from any state. pause or ~ena freezes the state,
// the counters and the LED pattern.
//
// Request semantics: start and ack are level-sampled, with no valid/ready
// pairing. start is honoured only while in IDLE and not frozen. ack is
// honoured only in DONE, and only while ena=1. A request that stays high
// keeps acting on each cycle in which it is eligible.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          design enable (low = frozen, start ignored)
//   start        start request, sampled in IDLE
//   ack          acknowledge, releases DONE
//   stop         abort to IDLE, highest priority
//   pause        freeze while high
//   step_limit   steps in RUN (0 means 8), latched on start
//   dwell_ticks  ticks spent in DWELL, latched on start
//   led_out      registered LED / segment pattern
//   state        current state code (IDLE=0, RUN=1, DWELL=2, DONE=3)
//   busy         high in RUN or DWELL
//   done         high in DONE
module led_seq_ctrl #(
    parameter logic [23:0] TICK_DIV = 24'd10_000_000,
    parameter int          DWELL_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               ack,
    input  logic               stop,
    input  logic               pause,
    input  logic [2:0]         step_limit,
    input  logic [DWELL_W-1:0] dwell_ticks,
    output logic [7:0]         led_out,
    output logic [1:0]         state,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             st, st_n;
    logic [23:0]        tick_cnt, tick_cnt_n;
    logic [2:0]         step, step_n;
    logic [3:0]         lim, lim_n;
    logic [DWELL_W-1:0] dwl, dwl_n;
    logic [DWELL_W-1:0] dwl_cnt, dwl_cnt_n;
    logic [7:0]         led_n;
    logic               frz;
    logic               tick;

    assign frz = pause | ~ena;

    // The prescaler wraps on its last count. It only advances in RUN and
    // DWELL while not frozen.
    assign tick = (tick_cnt == TICK_DIV - 24'd1) & ~frz &
                  ((st == S_RUN) | (st == S_DWELL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            tick_cnt <= '0;
            step     <= '0;
            lim      <= '0;
            dwl      <= '0;
            dwl_cnt  <= '0;
            led_out  <= 8'h00;
        end else begin
            st       <= st_n;
            tick_cnt <= tick_cnt_n;
            step     <= step_n;
            lim      <= lim_n;
            dwl      <= dwl_n;
            dwl_cnt  <= dwl_cnt_n;
            led_out  <= led_n;
        end
    end

    always_comb begin
        st_n       = st;
        tick_cnt_n = tick_cnt;
        step_n     = step;
        lim_n      = lim;
        dwl_n      = dwl;
        dwl_cnt_n  = dwl_cnt;

        if (stop) begin
            st_n       = S_IDLE;
            step_n     = '0;
            dwl_cnt_n  = '0;
            tick_cnt_n = '0;
        end else begin
            case (st)
                S_IDLE: begin
                    tick_cnt_n = '0;
                    if (start && !frz) begin
                        st_n      = S_RUN;
                        lim_n     = (step_limit == 3'd0) ? 4'd8 : {1'b0, step_limit};
                        dwl_n     = dwell_ticks;
                        step_n    = '0;
                        dwl_cnt_n = '0;
                    end
                end
                S_RUN: begin
                    if (!frz) begin
                        if (tick) begin
                            tick_cnt_n = '0;
                            // lim is at least 1, so lim-1 fits in step's 3 bits.
                            if ({1'b0, step} == lim - 4'd1) begin
                                st_n      = S_DWELL;
                                dwl_cnt_n = '0;
                            end else begin
                                step_n = step + 3'd1;
                            end
                        end else begin
                            tick_cnt_n = tick_cnt + 24'd1;
                        end
                    end
                end
                S_DWELL: begin
                    if (!frz) begin
                        if (dwl == '0) begin
                            st_n = S_DONE;
                        end else if (tick) begin
                            tick_cnt_n = '0;
                            if (dwl_cnt == dwl - DWELL_W'(1)) begin
                                st_n = S_DONE;
                            end else begin
                                dwl_cnt_n = dwl_cnt + DWELL_W'(1);
                            end
                        end else begin
                            tick_cnt_n = tick_cnt + 24'd1;
                        end
                    end
                end
                S_DONE: begin
                    tick_cnt_n = '0;
                    // pause does not block ack here; only a dropped ena does.
                    if (ack && ena) begin
                        st_n = S_IDLE;
                    end
                end
                default: st_n = S_IDLE;
            endcase

            // Every phase change starts the prescaler from zero.
            if (st_n != st) begin
                tick_cnt_n = '0;
            end
        end

        // The pattern is registered from the next state, so it changes on
        // the same edge as the state register.
        case (st_n)
            S_IDLE:  led_n = 8'h00;
            S_RUN:   led_n = {1'b0, step_n, 4'hA};
            S_DWELL: led_n = 8'h05;
            S_DONE:  led_n = 8'h0F;
            default: led_n = 8'h00;
        endcase
    end

    assign state = st;
    assign busy  = (st == S_RUN) | (st == S_DWELL);
    assign done  = (st == S_DONE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4 and DWELL_W=3.
module tb_led_seq_ctrl;

    localparam logic [23:0] TICK_DIV = 24'd4;
    localparam int          DWELL_W  = 3;

    logic               clk;
    logic               rst_n;
    logic               ena;
    logic               start;
    logic               ack;
    logic               stop;
    logic               pause;
    logic [2:0]         step_limit;
    logic [DWELL_W-1:0] dwell_ticks;
    logic [7:0]         led_out;
    logic [1:0]         state;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_errors = 0;

    led_seq_ctrl #(.TICK_DIV(TICK_DIV), .DWELL_W(DWELL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .ack         (ack),
        .stop        (stop),
        .pause       (pause),
        .step_limit  (step_limit),
        .dwell_ticks (dwell_ticks),
        .led_out     (led_out),
        .state       (state),
        .busy        (busy),
        .done        (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Check the outputs against an expected state and pattern for n cycles.
    task automatic expect_for(input string tag, input logic [1:0] exp_st,
                              input logic [7:0] exp_led, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, ".state"}, 32'(state), 32'(exp_st));
            check({tag, ".led"},   32'(led_out), 32'(exp_led));
            check({tag, ".busy"},  32'(busy), 32'((exp_st == 2'd1) || (exp_st == 2'd2)));
            check({tag, ".done"},  32'(done), 32'(exp_st == 2'd3));
            cyc();
        end
    endtask

    task automatic pulse_start(input logic [2:0] lim, input logic [DWELL_W-1:0] dw);
        step_limit  = lim;
        dwell_ticks = dw;
        start       = 1'b1;
        cyc();
        start       = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; ack = 1'b0;
        stop = 1'b0; pause = 1'b0; step_limit = '0; dwell_ticks = '0;

        // reset values
        #3;
        check("rst.state", 32'(state), 32'd0);
        check("rst.led",   32'(led_out), 32'h00);
        check("rst.busy",  32'(busy), 32'd0);
        check("rst.done",  32'(done), 32'd0);
        #4 rst_n = 1'b1;
        cyc(2);
        expect_for("idle", 2'd0, 8'h00, 1);

        // basic run: 3 steps of 4 cycles, dwell 2 ticks = 8 cycles
        pulse_start(3'd3, 3'd2);
        expect_for("b.run0", 2'd1, 8'h0A, 4);
        expect_for("b.run1", 2'd1, 8'h1A, 4);
        expect_for("b.run2", 2'd1, 8'h2A, 4);
        expect_for("b.dwell", 2'd2, 8'h05, 8);
        expect_for("b.done", 2'd3, 8'h0F, 3);
        do_ack();
        expect_for("b.idle", 2'd0, 8'h00, 2);

        // step_limit 0 means 8 steps, dwell 0 means a single DWELL cycle
        pulse_start(3'd0, 3'd0);
        for (int s = 0; s < 8; s++) begin
            expect_for("z.run", 2'd1, 8'(8'h0A + s * 16), 4);
        end
        expect_for("z.dwell", 2'd2, 8'h05, 1);
        expect_for("z.done", 2'd3, 8'h0F, 1);
        do_ack();
        expect_for("z.idle", 2'd0, 8'h00, 1);

        // pause 5 cycles at tick_cnt=2 of step 1
        pulse_start(3'd3, 3'd0);
        expect_for("p.run0", 2'd1, 8'h0A, 4);
        expect_for("p.run1a", 2'd1, 8'h1A, 2);
        pause = 1'b1;
        expect_for("p.hold", 2'd1, 8'h1A, 5);
        pause = 1'b0;
        expect_for("p.run1b", 2'd1, 8'h1A, 2);
        expect_for("p.run2", 2'd1, 8'h2A, 4);
        expect_for("p.dwell", 2'd2, 8'h05, 1);
        expect_for("p.done", 2'd3, 8'h0F, 1);
        // ack under pause is still honoured
        pause = 1'b1;
        do_ack();
        pause = 1'b0;
        expect_for("p.idle", 2'd0, 8'h00, 1);

        // stop in DWELL together with ack and pause
        pulse_start(3'd1, 3'd3);
        expect_for("s.run0", 2'd1, 8'h0A, 4);
        expect_for("s.dwell", 2'd2, 8'h05, 2);
        stop = 1'b1; ack = 1'b1; pause = 1'b1;
        cyc();
        stop = 1'b0; ack = 1'b0; pause = 1'b0;
        expect_for("s.idle", 2'd0, 8'h00, 2);
        pulse_start(3'd2, 3'd0);
        expect_for("s.rerun0", 2'd1, 8'h0A, 4);
        expect_for("s.rerun1", 2'd1, 8'h1A, 4);
        expect_for("s.dwell2", 2'd2, 8'h05, 1);
        expect_for("s.done", 2'd3, 8'h0F, 1);
        // ack with ena low is not honoured
        ena = 1'b0; ack = 1'b1;
        cyc();
        ack = 1'b0; ena = 1'b1;
        expect_for("s.done_noena", 2'd3, 8'h0F, 1);
        do_ack();
        expect_for("s.idle2", 2'd0, 8'h00, 1);

        // async reset mid-RUN, then start gated by ena
        pulse_start(3'd4, 3'd1);
        expect_for("r.run0", 2'd1, 8'h0A, 3);
        #2 rst_n = 1'b0;
        #1;
        check("r.async.state", 32'(state), 32'd0);
        check("r.async.led",   32'(led_out), 32'h00);
        check("r.async.busy",  32'(busy), 32'd0);
        #1 rst_n = 1'b1;
        cyc();
        ena = 1'b0; start = 1'b1;
        cyc();
        expect_for("r.noena", 2'd0, 8'h00, 3);
        ena = 1'b1;
        cyc();
        start = 1'b0;
        expect_for("r.run", 2'd1, 8'h0A, 2);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_for("r.stop", 2'd0, 8'h00, 1);

        // inputs changed after start are ignored; start held through DONE
        pulse_start(3'd2, 3'd0);
        step_limit = 3'd5; dwell_ticks = 3'd7;
        expect_for("l.run0", 2'd1, 8'h0A, 4);
        expect_for("l.run1", 2'd1, 8'h1A, 4);
        expect_for("l.dwell", 2'd2, 8'h05, 1);
        start = 1'b1;
        expect_for("l.done", 2'd3, 8'h0F, 3);
        do_ack();
        expect_for("l.idle", 2'd0, 8'h00, 1);
        start = 1'b0;
        expect_for("l.restart", 2'd1, 8'h0A, 4);
        expect_for("l.restart1", 2'd1, 8'h1A, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
